// File: rtl/nfca_seq_pkg.sv
// Shared types and constants for the NFC-A poll sequencer.
// Optional build macro: NFCA_POLL_BCC_CHECK_EN (see nfca_poll_sequencer.sv).
package nfca_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TX_REQA = 3'd1,
        ST_RX_ATQA = 3'd2,
        ST_GUARD   = 3'd3,
        ST_TX_ACOL = 3'd4,
        ST_RX_UID  = 3'd5,
        ST_WAIT    = 3'd6
    } state_t;

    // ISO14443A command bytes
    localparam logic [7:0] REQA     = 8'h26;
    localparam logic [7:0] SEL_CL1  = 8'h93;
    localparam logic [7:0] NVB_ACOL = 8'h20;

    // Poll cycle result codes
    localparam logic [1:0] RES_NONE  = 2'd0;
    localparam logic [1:0] RES_OK    = 2'd1;
    localparam logic [1:0] RES_RXERR = 2'd2;
    localparam logic [1:0] RES_BCC   = 2'd3;

    // Expected response lengths in bytes
    localparam logic [2:0] ATQA_LEN = 3'd2;
    localparam logic [2:0] UID_LEN  = 3'd5;

    // Valid-bit counts of a full byte and of the 7-bit REQA short frame
    localparam logic [3:0] DATAB_FULL  = 4'd8;
    localparam logic [3:0] DATAB_SHORT = 4'd7;

    // Block check character of a cascade-level-1 UID {uid0, uid1, uid2, uid3}
    function automatic logic [7:0] uid_bcc(input logic [31:0] uid);
        return uid[31:24] ^ uid[23:16] ^ uid[15:8] ^ uid[7:0];
    endfunction

endpackage

// File: rtl/nfca_seq_timer.sv
// Loadable down counter that saturates at zero and flags when it is zero.
module nfca_seq_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    input  logic         i_dec,
    output logic         o_zero
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] r_count;

    // Load wins over decrement; the count sticks at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - ONE;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/nfca_poll_sequencer.sv
// NFC-A poll sequencer: REQA -> ATQA -> guard -> ANTICOLLISION CL1 -> UID+BCC.
// Optional build macro: NFCA_POLL_BCC_CHECK_EN enables the UID BCC check
// (result 3 on mismatch); without it the BCC byte is ignored.
module nfca_poll_sequencer
    import nfca_seq_pkg::*;
#(
    parameter int POLL_PERIOD  = 8136000,
    parameter int RX_TIMEOUT   = 81360,
    parameter int GUARD_CYCLES = 40680
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        poll_en,
    output logic        tx_tvalid,
    input  logic        tx_tready,
    output logic [7:0]  tx_tdata,
    output logic [3:0]  tx_tdatab,
    output logic        tx_tlast,
    input  logic        rx_on,
    input  logic        rx_tvalid,
    input  logic [7:0]  rx_tdata,
    input  logic [3:0]  rx_tdatab,
    input  logic        rx_tend,
    input  logic        rx_terr,
    output logic        busy,
    output logic        done,
    output logic [1:0]  result,
    output logic [15:0] card_atqa,
    output logic [31:0] card_uid
);

    localparam int PW = $clog2(POLL_PERIOD + 1);
    localparam int TW = $clog2(((RX_TIMEOUT > GUARD_CYCLES) ? RX_TIMEOUT : GUARD_CYCLES) + 1);
    // Load values are one/two short because the counter is loaded the cycle
    // before the timed window starts and the state change costs one cycle.
    localparam logic [PW-1:0] PERIOD_LOAD  = PW'(POLL_PERIOD - 2);
    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(RX_TIMEOUT - 1);
    localparam logic [TW-1:0] GUARD_LOAD   = TW'(GUARD_CYCLES - 1);

    state_t          r_state, w_state_nxt;
    logic            r_acol_idx, w_acol_idx_nxt;
    logic            r_tx_valid, w_tx_valid_nxt;
    logic [7:0]      r_tx_data, w_tx_data_nxt;
    logic [3:0]      r_tx_datab, w_tx_datab_nxt;
    logic            r_tx_last, w_tx_last_nxt;
    logic            r_busy, r_done;
    logic [1:0]      r_result, w_result;
    logic [15:0]     r_card_atqa;
    logic [31:0]     r_card_uid;
    logic [2:0]      r_rx_cnt, w_cnt_eff;
    logic [3:0]      r_rx_datab, w_datab_eff;
    logic [4:0][7:0] r_rx_bytes, w_bytes_eff;
    logic            w_per_load, w_per_zero, w_tmr_load, w_tmr_zero, w_tmr_dec;
    logic [TW-1:0]   w_tmr_value;
    logic            w_rx_active, w_rx_clear, w_finish, w_atqa_ok, w_uid_ok, w_tx_hs;
    logic            w_unused_rx_on;

    // The timeout runs regardless of the controller's RX window flag.
    assign w_unused_rx_on = rx_on;

    assign w_tx_hs     = r_tx_valid && tx_tready;
    assign w_rx_active = (r_state == ST_RX_ATQA) || (r_state == ST_RX_UID);
    assign w_tmr_dec   = w_rx_active || (r_state == ST_GUARD);

    nfca_seq_timer #(.W(PW)) u_period (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_per_load),
        .i_value (PERIOD_LOAD),
        .i_dec   (1'b1),
        .o_zero  (w_per_zero)
    );

    nfca_seq_timer #(.W(TW)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_value),
        .i_dec   (w_tmr_dec),
        .o_zero  (w_tmr_zero)
    );

    // Frame view including a byte that arrives together with rx_tend.
    always_comb begin
        w_bytes_eff = r_rx_bytes;
        w_cnt_eff   = (rx_tvalid && (r_rx_cnt != 3'd7)) ? (r_rx_cnt + 3'd1) : r_rx_cnt;
        w_datab_eff = rx_tvalid ? rx_tdatab : r_rx_datab;
        for (int i = 0; i < 5; i++) begin
            if (rx_tvalid && (r_rx_cnt == 3'(i))) begin
                w_bytes_eff[i] = rx_tdata;
            end else begin
                w_bytes_eff[i] = r_rx_bytes[i];
            end
        end
    end

    // Next-state, counter control and next TX byte.
    always_comb begin
        w_state_nxt    = r_state;
        w_acol_idx_nxt = r_acol_idx;
        w_per_load     = 1'b0;
        w_tmr_load     = 1'b0;
        w_tmr_value    = TIMEOUT_LOAD;
        w_rx_clear     = 1'b0;
        w_finish       = 1'b0;
        w_result       = r_result;
        w_atqa_ok      = 1'b0;
        w_uid_ok       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (poll_en) begin
                    w_per_load  = 1'b1;
                    w_state_nxt = ST_TX_REQA;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_TX_REQA: begin
                if (w_tx_hs) begin
                    w_state_nxt = ST_RX_ATQA;
                    w_tmr_load  = 1'b1;
                    w_rx_clear  = 1'b1;
                end else begin
                    w_state_nxt = ST_TX_REQA;
                end
            end
            ST_RX_ATQA: begin
                if (rx_tend) begin
                    if (rx_terr || (w_cnt_eff != ATQA_LEN) || (w_datab_eff != DATAB_FULL)) begin
                        w_finish    = 1'b1;
                        w_result    = RES_RXERR;
                        w_state_nxt = ST_WAIT;
                    end else begin
                        w_atqa_ok   = 1'b1;
                        w_tmr_load  = 1'b1;
                        w_tmr_value = GUARD_LOAD;
                        w_state_nxt = ST_GUARD;
                    end
                end else if (w_tmr_zero) begin
                    w_finish    = 1'b1;
                    w_result    = RES_NONE;
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_RX_ATQA;
                end
            end
            ST_GUARD: begin
                if (w_tmr_zero) begin
                    w_acol_idx_nxt = 1'b0;
                    w_state_nxt    = ST_TX_ACOL;
                end else begin
                    w_state_nxt = ST_GUARD;
                end
            end
            ST_TX_ACOL: begin
                if (w_tx_hs && !r_acol_idx) begin
                    w_acol_idx_nxt = 1'b1;
                end else if (w_tx_hs) begin
                    w_acol_idx_nxt = 1'b0;
                    w_tmr_load     = 1'b1;
                    w_rx_clear     = 1'b1;
                    w_state_nxt    = ST_RX_UID;
                end else begin
                    w_state_nxt = ST_TX_ACOL;
                end
            end
            ST_RX_UID: begin
                if (rx_tend) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_WAIT;
                    if (rx_terr || (w_cnt_eff != UID_LEN) || (w_datab_eff != DATAB_FULL)) begin
                        w_result = RES_RXERR;
`ifdef NFCA_POLL_BCC_CHECK_EN
                    end else if (w_bytes_eff[4] != uid_bcc({w_bytes_eff[0], w_bytes_eff[1],
                                                            w_bytes_eff[2], w_bytes_eff[3]})) begin
                        w_result = RES_BCC;
`endif
                    end else begin
                        w_result = RES_OK;
                        w_uid_ok = 1'b1;
                    end
                end else if (w_tmr_zero) begin
                    w_finish    = 1'b1;
                    w_result    = RES_NONE;
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_RX_UID;
                end
            end
            ST_WAIT: begin
                if (w_per_zero) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_tx_valid_nxt = (w_state_nxt == ST_TX_REQA) || (w_state_nxt == ST_TX_ACOL);
        if (w_state_nxt == ST_TX_REQA) begin
            w_tx_data_nxt  = REQA;
            w_tx_datab_nxt = DATAB_SHORT;
            w_tx_last_nxt  = 1'b1;
        end else if (w_state_nxt == ST_TX_ACOL) begin
            w_tx_data_nxt  = w_acol_idx_nxt ? NVB_ACOL : SEL_CL1;
            w_tx_datab_nxt = DATAB_FULL;
            w_tx_last_nxt  = w_acol_idx_nxt;
        end else begin
            w_tx_data_nxt  = 8'h00;
            w_tx_datab_nxt = 4'd0;
            w_tx_last_nxt  = 1'b0;
        end
    end

    // State, TX byte and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_acol_idx  <= 1'b0;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= 8'h00;
            r_tx_datab  <= 4'd0;
            r_tx_last   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_result    <= RES_NONE;
            r_card_atqa <= 16'h0000;
            r_card_uid  <= 32'h0000_0000;
        end else begin
            r_state    <= w_state_nxt;
            r_acol_idx <= w_acol_idx_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_datab <= w_tx_datab_nxt;
            r_tx_last  <= w_tx_last_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_WAIT);
            r_done     <= w_finish;
            if (w_finish) begin
                r_result <= w_result;
            end
            if (w_atqa_ok) begin
                r_card_atqa <= {w_bytes_eff[1], w_bytes_eff[0]};
            end
            if (w_uid_ok) begin
                r_card_uid <= {w_bytes_eff[0], w_bytes_eff[1], w_bytes_eff[2], w_bytes_eff[3]};
            end
        end
    end

    // RX byte capture: cleared when a response window opens, counts saturate at 7.
    always_ff @(posedge clk) begin
        if (rst || w_rx_clear) begin
            r_rx_cnt   <= 3'd0;
            r_rx_datab <= 4'd0;
            r_rx_bytes <= '0;
        end else if (w_rx_active && rx_tvalid) begin
            r_rx_cnt   <= w_cnt_eff;
            r_rx_datab <= rx_tdatab;
            r_rx_bytes <= w_bytes_eff;
        end
    end

    assign tx_tvalid = r_tx_valid;
    assign tx_tdata  = r_tx_data;
    assign tx_tdatab = r_tx_datab;
    assign tx_tlast  = r_tx_last;
    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign card_atqa = r_card_atqa;
    assign card_uid  = r_card_uid;

endmodule

// File: tb/tb_nfca_poll_sequencer.sv
// Self-checking bench for nfca_poll_sequencer with shortened timing parameters.
module tb_nfca_poll_sequencer;

    localparam int P  = 200;
    localparam int RT = 40;
    localparam int G  = 20;
`ifdef NFCA_POLL_BCC_CHECK_EN
    localparam bit BCC_EN = 1'b1;
`else
    localparam bit BCC_EN = 1'b0;
`endif

    logic        clk, rst, poll_en;
    logic        tx_tvalid, tx_tready, tx_tlast;
    logic [7:0]  tx_tdata;
    logic [3:0]  tx_tdatab;
    logic        rx_on, rx_tvalid, rx_tend, rx_terr;
    logic [7:0]  rx_tdata;
    logic [3:0]  rx_tdatab;
    logic        busy, done;
    logic [1:0]  result;
    logic [15:0] card_atqa;
    logic [31:0] card_uid;

    nfca_poll_sequencer #(.POLL_PERIOD(P), .RX_TIMEOUT(RT), .GUARD_CYCLES(G)) dut (
        .clk(clk), .rst(rst), .poll_en(poll_en),
        .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tdata(tx_tdata),
        .tx_tdatab(tx_tdatab), .tx_tlast(tx_tlast),
        .rx_on(rx_on), .rx_tvalid(rx_tvalid), .rx_tdata(rx_tdata),
        .rx_tdatab(rx_tdatab), .rx_tend(rx_tend), .rx_terr(rx_terr),
        .busy(busy), .done(done), .result(result),
        .card_atqa(card_atqa), .card_uid(card_uid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          errors = 0;
    int          checks = 0;
    int          exp_done_cyc = -1000;
    logic [1:0]  exp_result = 2'd0;
    logic [15:0] exp_atqa = 16'h0000;
    logic [31:0] exp_uid = 32'h0;
    int          prev_start = -1;
    int          atqa_end = 0;
    bit          chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Spec-level verdict of a response frame: 2 = error/length, 3 = BCC, 1 = good.
    function automatic logic [1:0] frame_verdict(input bit is_uid, input logic [7:0][7:0] fb,
                                                 input int n, input logic [3:0] ldb, input bit terr);
        if (terr || n != (is_uid ? 5 : 2) || ldb != 4'd8) return 2'd2;
        if (is_uid && BCC_EN && ((fb[0] ^ fb[1] ^ fb[2] ^ fb[3]) != fb[4])) return 2'd3;
        return 2'd1;
    endfunction

    // Every-cycle compare: done timing, result/cards at done, AXIS hold rule.
    logic        p_valid = 1'b0, p_ready = 1'b0, p_rst = 1'b1;
    logic [12:0] p_fields = '0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("done_timing", {31'd0, done}, {31'd0, (cyc == exp_done_cyc)});
            if (done) begin
                chk("result", {30'd0, result}, {30'd0, exp_result});
                chk("card_atqa", {16'd0, card_atqa}, {16'd0, exp_atqa});
                chk("card_uid", card_uid, exp_uid);
            end
            if (p_valid && !p_ready && !p_rst) begin
                chk("tx_hold_valid", {31'd0, tx_tvalid}, 32'd1);
                chk("tx_hold_fields", {19'd0, tx_tdata, tx_tdatab, tx_tlast}, {19'd0, p_fields});
            end
            if (tx_tvalid) chk("busy_in_tx", {31'd0, busy}, 32'd1);
        end
        p_valid  = tx_tvalid;
        p_ready  = tx_tready;
        p_rst    = rst;
        p_fields = {tx_tdata, tx_tdatab, tx_tlast};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_tvalid"}, {31'd0, tx_tvalid}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_result"}, {30'd0, result}, 32'd0);
        chk({tag, "_atqa"}, {16'd0, card_atqa}, 32'd0);
        chk({tag, "_uid"}, card_uid, 32'd0);
    endtask

    task automatic wait_tx(input logic [7:0] d, input logic [3:0] db, input logic l,
                           input int stall, output int first_c, output int hs_c);
        int k;
        tx_tready = 1'b0;
        k = 0;
        while (!tx_tvalid && k < P + 20) begin
            step();
            k++;
        end
        chk("tx_wait", {31'd0, tx_tvalid}, 32'd1);
        first_c = cyc;
        chk("tx_tdata", {24'd0, tx_tdata}, {24'd0, d});
        chk("tx_tdatab", {28'd0, tx_tdatab}, {28'd0, db});
        chk("tx_tlast", {31'd0, tx_tlast}, {31'd0, l});
        repeat (stall) step();
        tx_tready = 1'b1;
        step();
        hs_c = cyc;
        tx_tready = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0][7:0] fb, input int n, input logic [3:0] ldb,
                              input bit terr, input bit coincide, input int tend_at, output int tend_c);
        int total;
        total = (coincide && n > 0) ? n : n + 1;
        tend_c = -1;
        if (tend_at > 0) begin
            while (cyc < tend_at - total) step();
        end
        rx_on = 1'b1;
        for (int i = 0; i < n; i++) begin
            rx_tvalid = 1'b1;
            rx_tdata  = fb[i];
            rx_tdatab = (i == n - 1) ? ldb : 4'd8;
            if (coincide && i == n - 1) begin
                rx_tend = 1'b1;
                rx_terr = terr;
                tend_c  = cyc + 1;
            end
            step();
        end
        if (!(coincide && n > 0)) begin
            rx_tvalid = 1'b0;
            rx_tend   = 1'b1;
            rx_terr   = terr;
            tend_c    = cyc + 1;
            step();
        end
        rx_tvalid = 1'b0; rx_tend = 1'b0; rx_terr = 1'b0;
        rx_tdata  = 8'h00; rx_tdatab = 4'd0; rx_on = 1'b0;
    endtask

    task automatic start_cycle(output int h);
        int f;
        wait_tx(8'h26, 4'd7, 1'b1, 0, f, h);
        if (prev_start >= 0) chk("poll_period", f - prev_start, P);
        prev_start = f;
    endtask

    task automatic do_atqa(input logic [7:0][7:0] fb, input int n, input logic [3:0] ldb,
                           input bit terr, input bit coincide, input int tend_at, output bit ok);
        int t;
        send_frame(fb, n, ldb, terr, coincide, tend_at, t);
        ok = (frame_verdict(1'b0, fb, n, ldb, terr) == 2'd1);
        if (ok) begin
            exp_atqa = {fb[1], fb[0]};
            atqa_end = t;
        end else begin
            exp_done_cyc = t;
            exp_result   = 2'd2;
        end
    endtask

    task automatic do_acol(input int stall);
        int f, h;
        wait_tx(8'h93, 4'd8, 1'b0, stall, f, h);
        chk("guard_gap", f, atqa_end + G);
        wait_tx(8'h20, 4'd8, 1'b1, 0, f, h);
    endtask

    task automatic do_uid(input logic [7:0][7:0] fb, input int n, input logic [3:0] ldb,
                          input bit terr, input bit coincide);
        int t;
        logic [1:0] v;
        send_frame(fb, n, ldb, terr, coincide, 0, t);
        v = frame_verdict(1'b1, fb, n, ldb, terr);
        exp_done_cyc = t;
        exp_result   = v;
        if (v == 2'd1) exp_uid = {fb[0], fb[1], fb[2], fb[3]};
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h;
        bit ok;
        logic [7:0][7:0] atqa_fb, uid_fb, uid2_fb;
        atqa_fb = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h44};
        uid_fb  = {8'h00, 8'h00, 8'h00, 8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h04};
        uid2_fb = {8'h00, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
        rst = 1'b1; poll_en = 1'b0; tx_tready = 1'b0;
        rx_on = 1'b0; rx_tvalid = 1'b0; rx_tdata = 8'h00; rx_tdatab = 4'd0;
        rx_tend = 1'b0; rx_terr = 1'b0;
        repeat (3) step();
        check_zero("reset");
        chk_en = 1'b1;
        rst = 1'b0;
        poll_en = 1'b1;

        // No card: timeout RT cycles after the REQA handshake, result 0
        start_cycle(h);
        exp_done_cyc = h + RT;
        exp_result   = 2'd0;

        // Good card, 0x93 stalled 10 cycles, BCC byte arrives with rx_tend
        start_cycle(h);
        do_atqa(atqa_fb, 2, 4'd8, 1'b0, 1'b0, 0, ok);
        if (ok) do_acol(10);
        do_uid(uid_fb, 5, 4'd8, 1'b0, 1'b1);
        chk("lit_ok_result", {30'd0, result}, 32'd1);
        chk("lit_ok_atqa", {16'd0, card_atqa}, 32'h0000_0044);
        chk("lit_ok_uid", card_uid, 32'h04A1_B2C3);

        // Wrong BCC for UID 11 22 33 44
        start_cycle(h);
        do_atqa(atqa_fb, 2, 4'd8, 1'b0, 1'b1, 0, ok);
        if (ok) do_acol(0);
        do_uid(uid2_fb, 5, 4'd8, 1'b0, 1'b1);
        chk("lit_bcc_result", {30'd0, result}, BCC_EN ? 32'd3 : 32'd1);
        chk("lit_bcc_uid", card_uid, BCC_EN ? 32'h04A1_B2C3 : 32'h1122_3344);

        // ATQA with rx_terr: result 2, next TX must be the next REQA
        start_cycle(h);
        do_atqa(atqa_fb, 2, 4'd8, 1'b1, 1'b0, 0, ok);

        // One-byte ATQA: result 2
        start_cycle(h);
        do_atqa(atqa_fb, 1, 4'd8, 1'b0, 1'b0, 0, ok);

        // ATQA ending exactly on the timeout edge is accepted; UID with bad last tdatab
        start_cycle(h);
        do_atqa(atqa_fb, 2, 4'd8, 1'b0, 1'b1, h + RT, ok);
        if (ok) do_acol(0);
        do_uid(uid_fb, 5, 4'd4, 1'b0, 1'b0);

        // poll_en dropped mid-cycle, then reset during RX_UID
        start_cycle(h);
        poll_en = 1'b0;
        do_atqa(atqa_fb, 2, 4'd8, 1'b0, 1'b0, 0, ok);
        if (ok) do_acol(0);
        rx_on = 1'b1; rx_tvalid = 1'b1; rx_tdata = 8'h04; rx_tdatab = 4'd8;
        step();
        rx_tdata = 8'hA1;
        step();
        rx_tvalid = 1'b0; rx_on = 1'b0;
        rst = 1'b1;
        step();
        check_zero("mid_reset");
        exp_result = 2'd0; exp_atqa = 16'h0; exp_uid = 32'h0;
        rst = 1'b0;
        for (int i = 0; i < 2 * P; i++) begin
            step();
            chk("idle_tvalid", {31'd0, tx_tvalid}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
